// File: rtl/kbd_input_ctrl.sv
// Keyboard input peripheral: detects new keystrokes on key_in and queues them
// in a small FIFO. The CPU reads them back through a status/data register pair.
module kbd_input_ctrl #(
    parameter int          DATA_W      = 64,
    parameter int          DEPTH       = 8,
    parameter logic [63:0] STATUS_ADDR = 64'h100,
    parameter logic [63:0] DATA_ADDR   = 64'h101
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] key_in,
    input  logic              rd_en,
    input  logic [63:0]       rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              irq,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;

    logic              key_evt;
    logic              empty;
    logic              full;
    logic              is_status;
    logic              is_data;
    logic              pop;
    logic              push;
    logic              drop;
    logic [DATA_W-1:0] status_word;

    // Decode keystroke events, CPU accesses and the resulting FIFO actions.
    // A pop frees a slot on the same edge, so a full FIFO still accepts a push
    // when it is being read.
    always_comb begin
        key_evt   = (key_in != key_q) && (key_in != '0);
        empty     = (count == '0);
        full      = (count == CW'(DEPTH));
        is_status = rd_en && (rd_addr == STATUS_ADDR);
        is_data   = rd_en && (rd_addr == DATA_ADDR);
        pop       = is_data && !empty;
        push      = key_evt && (!full || pop);
        drop      = key_evt && full && !pop;

        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Assemble the status register image.
    always_comb begin
        status_word       = '0;
        status_word[0]    = !empty;
        status_word[1]    = full;
        status_word[2]    = overflow;
        status_word[23:8] = 16'(count);
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= key_in;
        end
    end

    // Edge-detect register, pointers, occupancy and interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            irq    <= 1'b0;
        end else begin
            key_q <= key_in;
            count <= count_nxt;
            irq   <= (count_nxt != '0);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Sticky overflow flag: a status read clears it, a drop on the same edge wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (is_status) begin
            overflow <= 1'b0;
        end
    end

    // Registered load result; holds its value when no read is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (is_status) begin
                rd_data <= status_word;
            end else if (pop) begin
                rd_data <= mem[rd_ptr];
            end else begin
                rd_data <= '0;
            end
        end
    end

endmodule
